// File: rtl/bram_write_control.sv
// Writes received UART bytes into consecutive BRAM addresses starting at 0 and flags done after MAX_DEPTH bytes.
// Optional running byte checksum is enabled by defining BRAM_WR_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for enable
// WAIT    | armed, waiting for the next rx_valid strobe
// WRITE   | we asserted for one cycle, address/din stable
// DONE    | MAX_DEPTH bytes stored, terminal until rst
module bram_write_control #(
    parameter int MAX_DEPTH = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] din,
    output logic              we,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              overrun,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_WRITE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   din_q, din_d;
    logic                we_q, we_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic [ADDR_W:0]     count_inc;

    assign count_inc = count_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        din_d     = din_q;
        we_d      = 1'b0;
        count_d   = count_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_WAIT;
                    address_d = '0;
                    count_d   = '0;
                end
            end
            S_WAIT: begin
                if (rx_valid) begin
                    din_d   = rx_data;
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // count saturates so it can never pass MAX_DEPTH
                count_d = (count_q == MAX_CNT) ? count_q : count_inc;
                if (count_inc == MAX_CNT) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    address_d = address_q + ADDR_W'(1);
                    state_d   = S_WAIT;
                end
                if (rx_valid) begin
                    overrun_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            address_q <= '0;
            din_q     <= '0;
            we_q      <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            din_q     <= din_d;
            we_q      <= we_d;
            count_q   <= count_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef BRAM_WR_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == S_IDLE && enable) begin
            checksum_d = '0;
        end else if (state_q == S_WRITE) begin
            checksum_d = checksum_q + din_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign address = address_q;
    assign din     = din_q;
    assign we      = we_q;
    assign count   = count_q;
    assign done    = done_q;
    assign overrun = overrun_q;

endmodule
